// File: rtl/dmem_responder.sv
// dmem_responder: single-port data scratchpad answering the pipeline's dmem
// request interface. One request outstanding at a time. Byte-masked
// read/write is performed once, LATENCY cycles after the request is first
// seen, and completion is signalled by a one-cycle dmem_resp pulse.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // The counter only needs to hold LATENCY-1; keep at least one bit.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Request fields captured in IDLE; only these are used once busy.
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       rmask_q;
  logic [3:0]       wmask_q;
  logic [31:0]      wdata_q;

  logic [31:0]      rdata_q;
  logic             resp_q;

  logic             req;
  logic [IDX_W-1:0] req_idx;
  logic             capture;

  // Access port: the one place where the array is read and written.
  logic             acc_en;
  logic [IDX_W-1:0] acc_idx;
  logic [3:0]       acc_rmask;
  logic [3:0]       acc_wmask;
  logic [31:0]      acc_wdata;
  logic [31:0]      rd_word;
  logic [31:0]      rd_masked;

  logic [31:0]      mem [DEPTH_WORDS];

  // Byte offset and address bits above the array size are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{dmem_addr[31:IDX_W+2], dmem_addr[1:0]};

  assign req     = |(dmem_rmask | dmem_wmask);
  assign req_idx = dmem_addr[2 +: IDX_W];

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->)* RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output/control decode: capture strobe and access-port source selection.
  always_comb begin
    busy      = (state_q != IDLE);
    capture   = 1'b0;
    acc_en    = 1'b0;
    acc_idx   = idx_q;
    acc_rmask = rmask_q;
    acc_wmask = wmask_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE && req) begin
      capture = 1'b1;
      // With single-cycle latency the access happens at the accepting edge,
      // so it has to use the live request rather than the captured copy.
      if (LATENCY == 1) begin
        acc_en    = 1'b1;
        acc_idx   = req_idx;
        acc_rmask = dmem_rmask;
        acc_wmask = dmem_wmask;
        acc_wdata = dmem_wdata;
      end
    end
    if (state_q == WAIT && cnt_q == CNT_W'(1)) begin
      acc_en = 1'b1;
    end
    // The array has no reset, so a held reset must not let an access through.
    if (rst) begin
      acc_en = 1'b0;
    end
  end

  assign rd_word = mem[acc_idx];

  // Per-lane read masking: lanes not requested read as zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_masked[8*gi +: 8] = acc_rmask[gi] ? rd_word[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // Capture the request fields when a request is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      idx_q   <= req_idx;
      rmask_q <= dmem_rmask;
      wmask_q <= dmem_wmask;
      wdata_q <= dmem_wdata;
    end
  end

  // Byte-masked array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (acc_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered response pulse and read data (old word on combined read/write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= (state_d == RESP);
      if (acc_en) begin
        rdata_q <= rd_masked;
      end
    end
  end

  assign dmem_resp  = resp_q;
  assign dmem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with
// LATENCY=1 and one with LATENCY=3, sharing a clock.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3;
  logic [31:0] addr1, addr3, wdata1, wdata3, rdata1, rdata3;
  logic [3:0]  rmask1, rmask3, wmask1, wmask3;
  logic        resp1, resp3, busy1, busy3;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1), .dmem_addr(addr1), .dmem_rmask(rmask1),
    .dmem_wmask(wmask1), .dmem_wdata(wdata1), .dmem_rdata(rdata1),
    .dmem_resp(resp1), .busy(busy1)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .dmem_addr(addr3), .dmem_rmask(rmask3),
    .dmem_wmask(wmask3), .dmem_wdata(wdata3), .dmem_rdata(rdata3),
    .dmem_resp(resp3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int which, input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd);
    if (which == 3) begin
      addr3 = a; rmask3 = rm; wmask3 = wm; wdata3 = wd;
    end else begin
      addr1 = a; rmask1 = rm; wmask1 = wm; wdata1 = wd;
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE. Presents the request
  // and checks dmem_resp/busy in every cycle up to the response cycle.
  task automatic do_req(input int which, input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd,
                        input logic chk_rd, input logic [31:0] exp_rd,
                        input logic scramble, input string tag);
    int lat = (which == 3) ? 3 : 1;
    logic [31:0] r_obs, b_obs, d_obs;
    set_in(which, a, rm, wm, wd);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      r_obs = {31'd0, (which == 3) ? resp3 : resp1};
      b_obs = {31'd0, (which == 3) ? busy3 : busy1};
      d_obs = (which == 3) ? rdata3 : rdata1;
      chk($sformatf("%s resp c%0d", tag, k), r_obs, {31'd0, (k == lat)});
      chk($sformatf("%s busy c%0d", tag, k), b_obs, {31'd0, (k >= 1)});
      if (k == lat && chk_rd) chk($sformatf("%s rdata", tag), d_obs, exp_rd);
      @(posedge clk); #1;
      // While busy, the initiator's lines wander; the DUT must ignore them.
      if (scramble && k < lat) set_in(which, a + 32'h4, rm, wm, ~wd);
    end
    set_in(which, 32'h0, 4'h0, 4'h0, 32'h0);
    $display("txn %-14s lat=%0d addr=%h rm=%b wm=%b wd=%h", tag, lat, a, rm, wm, wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    set_in(1, 32'h0, 4'h0, 4'h0, 32'h0);
    set_in(3, 32'h0, 4'h0, 4'h0, 32'h0);
    #2;
    chk("rst resp1",  {31'd0, resp1}, 32'd0);
    chk("rst busy1",  {31'd0, busy1}, 32'd0);
    chk("rst rdata1", rdata1, 32'h0);
    chk("rst resp3",  {31'd0, resp3}, 32'd0);
    chk("rst busy3",  {31'd0, busy3}, 32'd0);
    chk("rst rdata3", rdata3, 32'h0);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    // LATENCY=1: full word, lanes, aliasing, combined masks (back-to-back).
    do_req(1, 32'h10,  4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, "l1 wr10");
    do_req(1, 32'h10,  4'hF, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, "l1 rd10");
    do_req(1, 32'h10,  4'h0, 4'h4, 32'h00AA0000, 1'b0, 32'h0,        1'b0, "l1 wrlane2");
    do_req(1, 32'h10,  4'h6, 4'h0, 32'h0,        1'b1, 32'h00AABE00, 1'b0, "l1 rd0110");
    do_req(1, 32'h13,  4'h1, 4'h0, 32'h0,        1'b1, 32'h000000EF, 1'b0, "l1 rd0001");
    do_req(1, 32'h400, 4'h0, 4'hF, 32'h11223344, 1'b0, 32'h0,        1'b0, "l1 wr400");
    do_req(1, 32'h0,   4'hF, 4'h0, 32'h0,        1'b1, 32'h11223344, 1'b0, "l1 rdalias");
    do_req(1, 32'h30,  4'h0, 4'hF, 32'h01020304, 1'b0, 32'h0,        1'b0, "l1 wr30");
    do_req(1, 32'h30,  4'hF, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h01020304, 1'b0, "l1 rdwr30");
    do_req(1, 32'h30,  4'hF, 4'h0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, "l1 rd30");

    // LATENCY=3: timing, ignored changes while busy.
    do_req(3, 32'h20,  4'h0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, "l3 wr20");
    do_req(3, 32'h20,  4'hF, 4'h0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, "l3 rd20");
    do_req(3, 32'h24,  4'h0, 4'hF, 32'hAAAAAAAA, 1'b0, 32'h0,        1'b1, "l3 wr24scr");
    do_req(3, 32'h24,  4'hF, 4'h0, 32'h0,        1'b1, 32'hAAAAAAAA, 1'b0, "l3 rd24");

    // LATENCY=3: reset asserted in cycle 2 of a write aborts it.
    set_in(3, 32'h20, 4'h0, 4'hF, 32'h12345678);
    @(negedge clk);
    chk("abort resp c0", {31'd0, resp3}, 32'd0);
    chk("abort busy c0", {31'd0, busy3}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort busy c1", {31'd0, busy3}, 32'd1);
    @(posedge clk); #1;
    rst3 = 1'b1;
    #1;
    chk("abort resp rst",  {31'd0, resp3}, 32'd0);
    chk("abort busy rst",  {31'd0, busy3}, 32'd0);
    chk("abort rdata rst", rdata3, 32'h0);
    set_in(3, 32'h0, 4'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk("abort resp after", {31'd0, resp3}, 32'd0);
    chk("abort busy after", {31'd0, busy3}, 32'd0);
    @(posedge clk); #1;
    $display("txn %-14s lat=3 addr=%h reset in WAIT", "l3 abort20", 32'h20);
    do_req(3, 32'h20,  4'hF, 4'h0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, "l3 rd20post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
